uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver downstream of uart_tx. Deserialises the 1-start / DATA_BITS-data (LSB first) / 1-even-parity / stop frame that uart_tx produces.
- Samples at mid-bit using the shared oversampling timer_tick. Presents the parallel word with a one-cycle done pulse, plus parity and framing status.
- Drives baudrate_gen_en so the shared baud generator runs only during a frame.

Parameters:
- DATA_BITS, 4, data bits per frame; must match uart_tx.
- TICKS_PER_DATABIT, 16, timer_tick periods per start, data or parity bit.
- STOP_BIT_TICKS, 16, timer_tick periods per stop bit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- timer_tick  input  1  one-clk pulse at TICKS_PER_DATABIT × baud rate.
- baudrate_gen_en  output  1  high whenever state is not idle; combinational from state.
- rx_dout  output  DATA_BITS  last received word; registered.
- rx_done_tick  output  1  one-clk pulse when a frame completes; registered.
- parity_err  output  1  received parity != ^rx_dout; valid with rx_done_tick, held until the next done.
- frame_err  output  1  stop-bit sample was 0; valid with rx_done_tick, held until the next done.

Behaviour:
- Reset values: rx_dout=0, rx_done_tick=0, parity_err=0, frame_err=0, state=idle, all counters 0, synchroniser flops=1.
- Reset asserted mid-frame: return to idle immediately, discard the partial word, do not pulse rx_done_tick.
- rx passes through a 2-flop synchroniser (rx_s). Pin-to-state latency is 2 clk.
- Tick counter width: clog2(max(TICKS_PER_DATABIT, STOP_BIT_TICKS))+1. Bit counter width: clog2(DATA_BITS)+1. Counters advance only on timer_tick and clear on every state change.
- States: idle, start, data, parity, stop.
- idle:
  - rx_s=0 → start, counters cleared.
  - Otherwise stay in idle.
- start:
  - On the tick where tick_cnt == TICKS_PER_DATABIT/2-1, sample rx_s (mid start bit).
  - Sample 0 → data, counters cleared.
  - Sample 1 → false start, back to idle, no outputs change.
- data:
  - On the tick where tick_cnt == TICKS_PER_DATABIT-1, shift the sample into shift_reg[bit_cnt] (LSB first) and increment bit_cnt.
  - When bit_cnt == DATA_BITS-1 at that sample → parity.
- parity:
  - On the tick where tick_cnt == TICKS_PER_DATABIT-1, capture par_bit → stop.
- stop:
  - On the tick where tick_cnt == STOP_BIT_TICKS-1 (mid stop bit), on the next clk:
    - rx_dout ← shift_reg
    - parity_err ← par_bit ^ (^shift_reg)
    - frame_err ← ~sample
    - rx_done_tick=1 for exactly one clk.
  - Go to idle. A following start edge during the remaining half stop bit is legal and is accepted from idle.
- A frame with errors is still delivered. rx_dout is updated regardless of parity_err or frame_err.
- timer_tick while in idle is ignored.
- baudrate_gen_en drops the same cycle state returns to idle. The generator restarts phase-aligned on the next frame.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, parity, stop) uses the 2-of-3 majority of rx_s captured on ticks at count-2, count-1 and count, where count is the nominal sample count. Adds a 2-bit sample history register.
- Undefined: single sample at the nominal count, as described above.
- Sample timing and output timing are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (idle=3'b000, start=3'b001, data=3'b010, parity=3'b011, stop=3'b100), shared with uart_tx;
  - default DATA_BITS, TICKS_PER_DATABIT and STOP_BIT_TICKS constants.
- One sub-module, uart_rx_sync: 2-flop synchroniser, reset value 1, parameterised reset level.

Test Plan:
- Loopback uart_tx→uart_rx on a shared 16× tick, tx_din=4'hA → rx_dout=4'hA, parity_err=0, frame_err=0, a single rx_done_tick pulse; baudrate_gen_en low afterwards.
- Sweep 4'h0..4'hF back-to-back with tx_start held → 16 done pulses in order, no errors, no dropped frames.
- Force the parity bit inverted on the wire for 4'h7 → rx_dout=4'h7, parity_err=1, frame_err=0; the next clean frame clears parity_err.
- Drive the stop bit low for 4'h3 → rx_dout=4'h3, frame_err=1.
- Glitch: rx low for 3 ticks then high → return to idle, no rx_done_tick, outputs unchanged. With UART_RX_MAJORITY_EN, a single-tick low spike inside data bit 2 of 4'hF → rx_dout=4'hF.
- Assert reset at data bit 2 → all outputs 0 in the same cycle (asynchronous), no pulse; the next full frame 4'h5 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common to uart_tx and uart_rx)
// and default frame-format constants.
package uart_pkg;

  // State encoding shared by transmitter and receiver.
  localparam logic [2:0] UART_IDLE   = 3'b000;
  localparam logic [2:0] UART_START  = 3'b001;
  localparam logic [2:0] UART_DATA   = 3'b010;
  localparam logic [2:0] UART_PARITY = 3'b011;
  localparam logic [2:0] UART_STOP   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = UART_IDLE,
    ST_START  = UART_START,
    ST_DATA   = UART_DATA,
    ST_PARITY = UART_PARITY,
    ST_STOP   = UART_STOP
  } uart_state_t;

  // Default frame format: 4 data bits, 16 ticks per bit.
  localparam int UART_DATA_BITS         = 4;
  localparam int UART_TICKS_PER_DATABIT = 16;
  localparam int UART_STOP_BIT_TICKS    = 16;

  // Larger of two integers, used to size the shared tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_LEVEL so an idle line produces no false edge.
module uart_rx_sync #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_LEVEL;
      q    <= RESET_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 even parity, 1 stop.
// Samples mid-bit on the shared oversampling timer_tick and reports the word
// with a one-cycle rx_done_tick plus parity and framing status.
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes the 2-of-3
// majority of rx_s on the ticks at count-2, count-1 and count.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS         = UART_DATA_BITS,
  parameter int TICKS_PER_DATABIT = UART_TICKS_PER_DATABIT,
  parameter int STOP_BIT_TICKS    = UART_STOP_BIT_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 timer_tick,
  output logic                 baudrate_gen_en,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = $clog2(max_int(TICKS_PER_DATABIT, STOP_BIT_TICKS)) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] START_MID    = TW'(TICKS_PER_DATABIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(TICKS_PER_DATABIT - 1);
  localparam logic [TW-1:0] STOP_LAST    = TW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_CNT_LAST = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 rx_s;
  logic                 sample;

  uart_rx_sync #(
    .RESET_LEVEL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Keep the synchronised line value from the two most recent ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (timer_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // The generator only needs to run while a frame is in progress.
  assign baudrate_gen_en = (state != ST_IDLE);

  // Frame sequencer, tick/bit counters, deserialiser and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (timer_tick) begin
            if (tick_cnt == START_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= sample ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (timer_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt                 <= '0;
              shift_reg[bit_cnt[IW-1:0]] <= sample;
              if (bit_cnt == BIT_CNT_LAST) begin
                bit_cnt <= '0;
                state   <= ST_PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (timer_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_bit  <= sample;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (timer_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt     <= '0;
              rx_dout      <= shift_reg;
              parity_err   <= par_bit ^ (^shift_reg);
              frame_err    <= ~sample;
              rx_done_tick <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
